// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data port. Data wins contention unless fetch
// has been passed over MAX_STARVE times in a row. Each winning request is
// latched toward memory, and a one-cycle ready pulse reports completion. If
// no mem_ack arrives within TIMEOUT cycles, the access completes with err set.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    // data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    // status
    output logic                err,
    output logic [1:0]          owner
);

    localparam int SC_W = $clog2(MAX_STARVE + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(MAX_STARVE);
    localparam logic [WC_W-1:0] WAIT_LAST    = WC_W'(TIMEOUT - 1);

    // The encoding doubles as the owner output: 00 idle, 01 fetch, 10 data.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic            if_req_m, d_req_m;
    logic            grant_i, grant_d;
    logic            in_grant, ack_hit, timeout_hit;
    logic [SC_W-1:0] starve_cnt;
    logic [WC_W-1:0] wait_cnt;

    // A requester still holding req during its own ready cycle is hidden so
    // it cannot immediately re-win the access it just completed.
    assign if_req_m = if_req & ~if_ready;
    assign d_req_m  = d_req  & ~d_ready;

    assign in_grant    = (state == GNT_I) || (state == GNT_D);
    assign ack_hit     = in_grant & mem_ack;
    assign timeout_hit = in_grant & ~mem_ack & (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and grant decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req_m && !(if_req_m && starve_cnt == STARVE_LIMIT)) begin
                    state_nxt = GNT_D;
                    grant_d   = 1'b1;
                end else if (if_req_m) begin
                    state_nxt = GNT_I;
                    grant_i   = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (ack_hit || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        mem_req = in_grant;
        owner   = state;
    end

    // Request latching, starvation/wait counters and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;

            // Fetches are always reads: never let a stale mask through.
            if (grant_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end else if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wmask <= d_wmask;
            end

            if (grant_i || grant_d) wait_cnt <= '0;
            else if (in_grant)      wait_cnt <= wait_cnt + 1'b1;

            if (grant_i)
                starve_cnt <= '0;
            else if (grant_d && if_req_m && starve_cnt != STARVE_LIMIT)
                starve_cnt <= starve_cnt + 1'b1;

            // Completion: ack returns data, timeout returns zero with err.
            if (state == GNT_I && (ack_hit || timeout_hit)) begin
                if_ready <= 1'b1;
                err      <= timeout_hit;
                if_rdata <= ack_hit ? mem_rdata : '0;
            end
            if (state == GNT_D && (ack_hit || timeout_hit)) begin
                d_ready <= 1'b1;
                err     <= timeout_hit;
                if (timeout_hit)  d_rdata <= '0;
                else if (!mem_we) d_rdata <= mem_rdata;
            end
        end
    end

endmodule
